// File: rtl/irq_pkg.sv
// Shared types and register map for the interrupt controller.
// Byte offsets are relative to the controller's base address.
package irq_pkg;

    typedef logic [1:0] prio_t;
    typedef logic [4:0] vector_t;

    // group count at the maximum of 32 sources (four sources per group)
    localparam int NUM_GROUPS = 8;

    localparam logic [23:0] PRIO_OFS    = 24'd0;
    localparam logic [23:0] ENABLE_OFS  = 24'd3;
    localparam logic [23:0] PENDING_OFS = 24'd7;
    localparam logic [23:0] REG_SPAN    = 24'd11;

endpackage

// File: rtl/irq_prio_select.sv
// Combinational winner selection: highest group priority, ties to the lowest index.
// A group priority of 0 can never win, so disabled groups drop out naturally.
module irq_prio_select
    import irq_pkg::*;
#(
    parameter int NUM_IRQS = 32
) (
    input  logic [NUM_IRQS-1:0]       eligible,
    input  logic [2*(NUM_IRQS/4)-1:0] group_prio,
    output logic                      valid,
    output vector_t                   vector,
    output prio_t                     prio
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        valid  = 1'b0;
        vector = '0;
        prio   = '0;
        // strict '>' while scanning upwards keeps the lowest index on a tie
        for (int i = 0; i < NUM_IRQS; i++) begin
            if (eligible[i] && (group_prio[2*(i/4) +: 2] > prio)) begin
                valid  = 1'b1;
                vector = vector_t'(i);
                prio   = group_prio[2*(i/4) +: 2];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latched pending flags, bus-mapped enable/priority,
// registered highest-priority request to the CPU with an ack handshake.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_IRQS  = 32,
    parameter logic [23:0] BASE_ADDR = 24'h2020
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                bus_write,
    input  logic                bus_read,
    input  logic [23:0]         bus_address_in,
    input  logic [7:0]          bus_data_in,
    output logic [7:0]          bus_data_out,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq_req,
    output vector_t             irq_vector,
    output prio_t               irq_prio,
    input  logic                irq_ack
);

    localparam int GROUPS = NUM_IRQS / 4;

    logic [2*GROUPS-1:0] prio_reg;
    logic [NUM_IRQS-1:0] enable;
    logic [NUM_IRQS-1:0] pending;
    logic [NUM_IRQS-1:0] irq_prev;

    logic [23:0]         offset;
    logic                hit;
    logic                wr;
    logic                ack_fire;
    logic [NUM_IRQS-1:0] rise;
    logic [NUM_IRQS-1:0] ack_mask;
    logic [NUM_IRQS-1:0] w1c_mask;
    logic [NUM_IRQS-1:0] eligible;

    logic                sel_valid;
    vector_t             sel_vector;
    prio_t               sel_prio;

    // addresses below the base wrap to large offsets and miss the window
    assign offset   = bus_address_in - BASE_ADDR;
    assign hit      = offset < REG_SPAN;
    assign wr       = bus_write && hit;
    assign ack_fire = irq_ack && irq_req;
    assign rise     = irq_in & ~irq_prev;
    assign ack_mask = ack_fire ? (NUM_IRQS'(1) << irq_vector) : '0;

    always_comb begin
        w1c_mask = '0;
        eligible = '0;
        for (int i = 0; i < NUM_IRQS; i++) begin
            w1c_mask[i] = wr && (offset == PENDING_OFS + 24'(i / 8)) && bus_data_in[i % 8];
            // the source being acked is excluded now so no stale vector follows the ack
            eligible[i] = pending[i] && enable[i] && !ack_mask[i];
        end
    end

    irq_prio_select #(.NUM_IRQS(NUM_IRQS)) u_select (
        .eligible   (eligible),
        .group_prio (prio_reg),
        .valid      (sel_valid),
        .vector     (sel_vector),
        .prio       (sel_prio)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_reg   <= '0;
            enable     <= '0;
            pending    <= '0;
            irq_prev   <= '0;
            irq_req    <= 1'b0;
            irq_vector <= '0;
            irq_prio   <= '0;
        end else begin
            irq_prev <= irq_in;
            // a rising edge wins over both clear sources on the same bit
            pending  <= rise | (pending & ~(w1c_mask | ack_mask));
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (wr && (offset == ENABLE_OFS + 24'(i / 8)))
                    enable[i] <= bus_data_in[i % 8];
            end
            for (int g = 0; g < GROUPS; g++) begin
                if (wr && (offset == PRIO_OFS + 24'(g / 4)))
                    prio_reg[2*g +: 2] <= bus_data_in[2*(g % 4) +: 2];
            end
            irq_req <= sel_valid;
            if (sel_valid) begin
                irq_vector <= sel_vector;
                irq_prio   <= sel_prio;
            end
        end
    end

    always_comb begin
        bus_data_out = '0;
        if (bus_read && hit) begin
            for (int i = 0; i < NUM_IRQS; i++) begin
                if (offset == ENABLE_OFS + 24'(i / 8))
                    bus_data_out[i % 8] = enable[i];
                if (offset == PENDING_OFS + 24'(i / 8))
                    bus_data_out[i % 8] = pending[i];
            end
            for (int g = 0; g < GROUPS; g++) begin
                if (offset == PRIO_OFS + 24'(g / 4))
                    bus_data_out[2*(g % 4) +: 2] = prio_reg[2*g +: 2];
            end
        end
    end

endmodule
